// File: rtl/rns_mrc_decoder_107.sv
// Two-channel RNS {107, 128} to binary reverse converter using iterative mixed-radix conversion.
// Optional input range checking on the mod-107 residue is enabled by defining MRC_RANGE_CHECK_EN.
module rns_mrc_decoder_107 #(
  parameter int M1      = 107,
  parameter int M2_BITS = 7,
  parameter int INV     = 67,
  parameter int OUT_W   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M2_BITS-1:0] in_r1,
  input  logic [M2_BITS-1:0] in_r2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_err
);

  localparam int                  CW     = $clog2(M2_BITS);
  localparam logic [CW-1:0]       LAST_I = CW'(M2_BITS - 1);
  localparam logic [M2_BITS-1:0]  INV_C  = M2_BITS'(INV);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state_q, state_d;
  logic [M2_BITS-1:0] r1_q, d_q, acc_q, acc_nxt;
  logic [CW-1:0]      i_q;
  logic [OUT_W-1:0]   out_data_q;
  logic [OUT_W-1:0]   result;
  logic               last_bit;

  assign last_bit = (i_q == LAST_I);

  // One shift-add step of t = d * INV mod 2^M2_BITS; the shift drops bits beyond the modulus.
  assign acc_nxt = d_q[i_q] ? (acc_q + (INV_C << i_q)) : acc_q;
  assign result  = OUT_W'(r1_q) + OUT_W'(M1) * OUT_W'(acc_nxt);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = MUL;
      MUL:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

`ifdef MRC_RANGE_CHECK_EN
  logic err_q, out_err_q;
  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q       <= '0;
      d_q        <= '0;
      acc_q      <= '0;
      i_q        <= '0;
      out_data_q <= '0;
`ifdef MRC_RANGE_CHECK_EN
      err_q      <= 1'b0;
      out_err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          r1_q  <= in_r1;
          d_q   <= in_r2 - in_r1;
          acc_q <= '0;
          i_q   <= '0;
`ifdef MRC_RANGE_CHECK_EN
          err_q <= (in_r1 > M2_BITS'(M1 - 1));
`endif
        end
        MUL: begin
          acc_q <= acc_nxt;
          i_q   <= i_q + 1'b1;
          if (last_bit) begin
`ifdef MRC_RANGE_CHECK_EN
            out_data_q <= err_q ? '0 : result;
            out_err_q  <= err_q;
`else
            out_data_q <= result;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_data_q;

endmodule
